// File: rtl/magnitude_search.sv
// Successive-approximation search initiator for a magnitude comparator.
// Recovers a hidden operand MSB first, then checks it with one equality query.
module magnitude_search #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             select,
    output logic             query_valid,
    input  logic             resp_valid,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_bit_idx;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic             r_error;
    logic [WIDTH-1:0] w_bit;
    logic             w_qv;
    logic             w_accept;

    assign w_bit    = WIDTH'(1) << r_bit_idx;
    assign w_qv     = (r_state == S_QUERY) || (r_state == S_VERIFY);
    assign w_accept = w_qv && resp_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_QUERY;
            S_QUERY:  if (w_accept && r_bit_idx == '0) w_next = S_VERIFY;
            S_VERIFY: if (w_accept) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_work    <= '0;
            r_result  <= '0;
            r_error   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bit_idx <= IW'(WIDTH - 1);
                        r_work    <= '0;
                        r_result  <= '0;
                        r_error   <= 1'b0;
                    end
                end
                S_QUERY: begin
                    if (w_accept) begin
                        // trial bit was set in guess; a 0 answer keeps it
                        if (!resp) r_work <= r_work | w_bit;
                        if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - IW'(1);
                    end
                end
                S_VERIFY: begin
                    if (w_accept) begin
                        r_result <= r_work;
                        r_error  <= resp;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        guess = '0;
        unique case (r_state)
            S_QUERY:  guess = r_work | w_bit;
            S_VERIFY: guess = r_work;
            default:  guess = '0;
        endcase
    end

    assign select      = (r_state == S_QUERY);
    assign query_valid = w_qv;
    assign busy        = w_qv;
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign error       = r_error;

endmodule
